// File: rtl/piano_pkg.sv
// piano_pkg: note indices, sequencer state encoding, ROM entry layout and one-hot note decode.
package piano_pkg;
    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D4   = 4'd2;
    localparam logic [3:0] NOTE_E4   = 4'd3;
    localparam logic [3:0] NOTE_F4   = 4'd4;
    localparam logic [3:0] NOTE_G4   = 4'd5;
    localparam logic [3:0] NOTE_A4   = 4'd6;
    localparam logic [3:0] NOTE_B4   = 4'd7;
    localparam logic [3:0] NOTE_C5   = 4'd8;
    localparam logic [3:0] NOTE_END  = 4'd15;

    localparam int ENT_NOTE_HI = 7;
    localparam int ENT_NOTE_LO = 4;
    localparam int ENT_DUR_HI  = 3;
    localparam int ENT_DUR_LO  = 0;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_PLAY, ST_GAP, ST_FINISH} seq_state_t;

    // Indices outside C4..C5 (rests, end marker) decode to silence.
    function automatic logic [11:0] note_onehot(input logic [3:0] idx);
        return (idx >= NOTE_C4 && idx <= NOTE_C5) ? 12'h001 << (idx - NOTE_C4) : 12'h000;
    endfunction
endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: control, live-key and piezo-side signals of the note sequencer.
interface note_sequencer_if #(parameter int ADDR_W = 5) ();
    logic              play_start;
    logic              play_stop;
    logic [11:0]       key_in;
    logic              key_valid;
    logic [11:0]       note_out;
    logic              note_valid;
    logic              busy;
    logic [ADDR_W-1:0] song_pos;
    logic              done;

    modport master (output play_start, play_stop, key_in, key_valid,
                    input  note_out, note_valid, busy, song_pos, done);
    modport slave  (input  play_start, play_stop, key_in, key_valid,
                    output note_out, note_valid, busy, song_pos, done);
endinterface

// File: rtl/song_rom.sv
// song_rom: fixed combinational melody table; unlisted addresses hold the end marker.
module song_rom
    import piano_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [7:0]        o_data
);
    always_comb begin
        case (32'(i_addr))
            0:       o_data = {NOTE_C4, 4'd2};
            1:       o_data = {NOTE_REST, 4'd1};
            2:       o_data = {NOTE_E4, 4'd0};
            default: o_data = {NOTE_END, 4'd0};
        endcase
    end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays song_rom note by note with live-key override and pause/resume.
// Define NOTE_SEQUENCER_LOOP_EN to restart the melody at address 0 instead of finishing.
module note_sequencer
    import piano_pkg::*;
#(
    parameter int TICK_DIV  = 250000,
    parameter int GAP_TICKS = 1,
    parameter int ROM_DEPTH = 32
) (
    input  logic           clk,
    input  logic           rst_x,
    note_sequencer_if.slave bus
);
    localparam int ADDR_W = $clog2(ROM_DEPTH);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int GAP_W  = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);

    seq_state_t        r_state, w_state;
    logic [ADDR_W-1:0] r_pos, w_pos;
    logic              r_over, w_over;
    logic [11:0]       r_note, w_note;
    logic [3:0]        r_dur, w_dur;
    logic [GAP_W-1:0]  r_gap, w_gap;
    logic [TICK_W-1:0] r_tick, w_tick_cnt;
    logic              w_tick, w_key, w_pause, w_done, w_adv;
    logic [7:0]        w_entry;
    logic [3:0]        w_idx, w_len;
    logic [11:0]       r_note_out;
    logic              r_note_valid, r_busy, r_done;

    song_rom #(.ADDR_W(ADDR_W)) u_rom (.i_addr(r_pos), .o_data(w_entry));

    assign w_idx   = w_entry[ENT_NOTE_HI:ENT_NOTE_LO];
    assign w_len   = w_entry[ENT_DUR_HI:ENT_DUR_LO];
    assign w_key   = bus.key_valid && (bus.key_in != '0);
    assign w_pause = w_key && (r_state inside {ST_LOAD, ST_PLAY, ST_GAP});
    assign w_tick  = r_tick == TICK_W'(TICK_DIV - 1);

    always_comb begin
        w_state    = r_state;
        w_pos      = r_pos;
        w_over     = r_over;
        w_note     = r_note;
        w_dur      = r_dur;
        w_gap      = r_gap;
        w_tick_cnt = r_tick;
        w_done     = 1'b0;
        w_adv      = 1'b0;
        if (bus.play_stop && r_state != ST_IDLE) begin
            w_state = ST_IDLE;
        end else if (!w_pause) begin
            case (r_state)
                ST_IDLE: if (bus.play_start && !bus.play_stop) begin
                    w_state = ST_LOAD;
                    w_pos   = '0;
                    w_over  = 1'b0;
                end
                ST_LOAD: if (r_over || w_idx == NOTE_END) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
                    w_state = ST_LOAD;
                    w_pos   = '0;
                    w_over  = 1'b0;
                    w_done  = 1'b1;
`else
                    w_state = ST_FINISH;
`endif
                end else begin
                    w_state    = ST_PLAY;
                    w_note     = note_onehot(w_idx);
                    w_dur      = (w_len == 4'd0) ? 4'd1 : w_len;
                    w_tick_cnt = '0;
                end
                ST_PLAY: begin
                    w_tick_cnt = w_tick ? '0 : r_tick + TICK_W'(1);
                    if (w_tick) begin
                        if (r_dur != 4'd1) w_dur = r_dur - 4'd1;
                        else if (GAP_TICKS > 0) begin
                            w_state = ST_GAP;
                            w_gap   = GAP_W'(GAP_TICKS);
                        end else w_adv = 1'b1;
                    end
                end
                ST_GAP: begin
                    w_tick_cnt = w_tick ? '0 : r_tick + TICK_W'(1);
                    if (w_tick) begin
                        if (r_gap != GAP_W'(1)) w_gap = r_gap - GAP_W'(1);
                        else w_adv = 1'b1;
                    end
                end
                ST_FINISH: w_state = ST_IDLE;
                default:   w_state = ST_IDLE;
            endcase
            // The last address never wraps; the overrun flag makes LOAD finish instead.
            if (w_adv) begin
                w_state = ST_LOAD;
                if (r_pos == ADDR_W'(ROM_DEPTH - 1)) w_over = 1'b1;
                else w_pos = r_pos + ADDR_W'(1);
            end
        end
        w_done = w_done || (w_state == ST_FINISH);
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_state      <= ST_IDLE;
            r_pos        <= '0;
            r_over       <= 1'b0;
            r_note       <= '0;
            r_dur        <= '0;
            r_gap        <= '0;
            r_tick       <= '0;
            r_note_out   <= '0;
            r_note_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_pos        <= w_pos;
            r_over       <= w_over;
            r_note       <= w_note;
            r_dur        <= w_dur;
            r_gap        <= w_gap;
            r_tick       <= w_tick_cnt;
            r_note_out   <= w_key ? bus.key_in : (w_state == ST_PLAY ? w_note : 12'h000);
            r_note_valid <= w_key || (w_state == ST_PLAY && w_note != 12'h000);
            r_busy       <= w_state inside {ST_LOAD, ST_PLAY, ST_GAP};
            r_done       <= w_done;
        end
    end

    assign bus.note_out   = r_note_out;
    assign bus.note_valid = r_note_valid;
    assign bus.busy       = r_busy;
    assign bus.song_pos   = r_pos;
    assign bus.done       = r_done;
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Sequences tone requests into the piezo tone generator. It either plays a stored melody note by note, or passes live keypad notes straight through.
- Sits between the keypad scanner and the piezo. It drives the piezo's 12-bit one-hot note code and its valid input.
- Live keys have priority: they pause the melody, and the melody resumes where it stopped once the keys are released.

Parameters:
- TICK_DIV, 250000: clk cycles per duration tick (250 ms at 1 MHz); minimum 2.
- GAP_TICKS, 1: silent ticks inserted after every melody note; 0 means no gap.
- ROM_DEPTH, 32: number of melody entries; address width is ADDR_W = clog2(ROM_DEPTH).

Ports:
- clk  in  1  system clock
- rst_x  in  1  asynchronous active-low reset
- play_start  in  1  single-cycle pulse: start the melody from address 0
- play_stop  in  1  single-cycle pulse: abort the melody
- key_in  in  12  one-hot live key code from the keypad scanner
- key_valid  in  1  a live key is held
- note_out  out  12  one-hot note code to the piezo
- note_valid  out  1  piezo enable
- busy  out  1  melody active, including while paused
- song_pos  out  ADDR_W  current melody address
- done  out  1  single-cycle pulse when the melody ends

Behaviour:
- Reset (async, rst_x=0), all state cleared:
  - FSM goes to IDLE.
  - note_out=0, note_valid=0, busy=0, song_pos=0, done=0.
  - Tick, duration and gap counters = 0.
- Timing: all outputs are registered. Every response appears one clk after its cause.
- ROM entry format, 8 bits:
  - [7:4] note index: 0 = rest; 1..8 = C4..C5 (bit index-1 of note_out); 9..14 = rest; 15 = end marker.
  - [3:0] duration in ticks; 0 is treated as 1.
- Tick generator:
  - Counts 0..TICK_DIV-1 while in PLAY or GAP and not paused.
  - tick asserts on the terminal count.
  - The counter clears on every note load.
- FSM states: IDLE, LOAD, PLAY, GAP, FINISH.
  - IDLE: play_start goes to LOAD with song_pos=0, busy=1.
  - LOAD: reads ROM[song_pos].
    - End marker, or song_pos past ROM_DEPTH-1: go to FINISH.
    - Otherwise: latch the note and duration, then go to PLAY.
  - PLAY: note_out = decoded note, note_valid = 1 (0 for a rest). Duration counts down on tick. When it expires:
    - GAP_TICKS>0: go to GAP.
    - GAP_TICKS=0: go to LOAD with song_pos+1.
  - GAP: note_out=0, note_valid=0 for GAP_TICKS ticks, then LOAD with song_pos+1.
  - FINISH: done=1 for one cycle, busy=0, note_valid=0, then IDLE.
- Live key arbitration (any state, when key_valid=1 and key_in≠0):
  - note_out=key_in, note_valid=1.
  - If busy, the melody FSM and all counters freeze (pause).
  - On release, the melody resumes in the same state with the same residual count.
  - A key_in with more than one bit set passes through unchanged.
- Simultaneous or redundant events:
  - play_stop beats play_start in the same cycle.
  - play_stop in any busy state goes to IDLE with busy=0 and no done pulse. It is honoured while paused.
  - play_start while busy is ignored.
  - play_stop in IDLE is a no-op.
- Wrap: song_pos never wraps. Overrunning ROM_DEPTH ends the melody exactly like an end marker.

Optional Feature:
- Macro: NOTE_SEQUENCER_LOOP_EN.
- Defined: the end marker, or overrun, returns to LOAD at song_pos=0 and pulses done once per pass. busy stays 1; only play_stop exits.
- Undefined: the melody ends at FINISH as described above.

Decomposition:
- Shared package piano_pkg holds:
  - the note index constants (NOTE_REST, NOTE_C4..NOTE_C5, NOTE_END);
  - the FSM state encoding;
  - the ROM entry field positions;
  - the index-to-one-hot decode function, also usable by the piezo limit table.
- Sub-module song_rom: combinational case-table ROM, addr in, 8-bit entry out, contents fixed in RTL.

Test Plan (TICK_DIV=4, GAP_TICKS=1, ROM = {C4,d2},{rest,d1},{E4,d0},{END}):
- Reset mid-PLAY (rst_x low for 1 cycle) -> all outputs 0 next cycle, FSM IDLE, a later play_start plays from address 0.
- play_start -> note_out=12'h001 for 8 clk, gap 4 clk, rest 4 clk, gap 4 clk, 12'h004 for 4 clk, gap 4 clk, done=1 one cycle, busy=0.
- During C4 with 3 clk elapsed, key_in=12'h080, key_valid=1 for 10 clk -> note_out=12'h080 during the key. C4 then resumes for exactly 5 more clk.
- play_start and play_stop in the same cycle while IDLE -> stays IDLE, busy=0. play_stop during E4 -> note_valid=0, busy=0, no done.
- ROM filled without an END entry -> song_pos reaches ROM_DEPTH-1, then done pulses and busy drops.
- With NOTE_SEQUENCER_LOOP_EN -> after END, song_pos=0 and C4 restarts. done pulses each pass, busy stays 1 until play_stop.
